// File: rtl/move_player_if.sv
// move_player_if: solver-side move strobe and display-side replay signals of the move player
interface move_player_if #(
    parameter int CNT_W = 10
);
    logic             clear;
    logic             en;
    logic [3:0]       mv_start;
    logic [3:0]       mv_end;
    logic [3:0]       mv_number;
    logic             solver_done;
    logic             step;
    logic             auto_play;
    logic             proceed;
    logic             stb;
    logic [3:0]       disp_start;
    logic [3:0]       disp_end;
    logic [3:0]       disp_number;
    logic [CNT_W-1:0] move_count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             done;

    modport master (
        output clear, en, mv_start, mv_end, mv_number, solver_done, step, auto_play,
        input  proceed, stb, disp_start, disp_end, disp_number, move_count,
               empty, full, overflow, done
    );

    modport slave (
        input  clear, en, mv_start, mv_end, mv_number, solver_done, step, auto_play,
        output proceed, stb, disp_start, disp_end, disp_number, move_count,
               empty, full, overflow, done
    );
endinterface

// File: rtl/move_player.sv
// move_player: buffers solver moves in a FIFO and replays them on step pulses or an auto-play timer
module move_player #(
    parameter int DEPTH       = 16,
    parameter int AUTO_PERIOD = 25_000_000,
    parameter int CNT_W       = 10
) (
    input logic          i_clk,
    input logic          i_rst_n,
    move_player_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nx;
    logic [11:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] moves;
    logic             empty, full, pop_req, pop, push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_req = bus.auto_play ? (timer == TW'(AUTO_PERIOD - 1)) : bus.step;
    assign pop     = pop_req && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts a push
    assign push    = bus.en && (!full || pop);
    assign bus.move_count = moves;

    // storage write; contents need no reset since pointers define validity
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {bus.mv_start, bus.mv_end, bus.mv_number};
    end

    // FIFO pointers, occupancy, replay display registers, counters and timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            timer        <= '0;
            moves        <= '0;
            bus.stb      <= 1'b0;
            bus.overflow <= 1'b0;
            {bus.disp_start, bus.disp_end, bus.disp_number} <= '0;
        end else if (bus.clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            timer        <= '0;
            moves        <= '0;
            bus.stb      <= 1'b0;
            bus.overflow <= 1'b0;
            {bus.disp_start, bus.disp_end, bus.disp_number} <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (bus.en && !push) bus.overflow <= 1'b1;
            bus.stb <= pop;
            if (pop) {bus.disp_start, bus.disp_end, bus.disp_number} <= mem[rd_ptr];
            if (pop && moves != '1) moves <= moves + 1'b1;
            timer <= (!bus.auto_play || empty || pop) ? '0 : timer + 1'b1;
        end
    end

    // FSM state register; clear always returns to normal running
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_RUN;
        else if (bus.clear) state <= S_RUN;
        else state <= state_nx;
    end

    // next state: latch solver completion, then wait for the FIFO to drain completely
    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:   if (bus.solver_done) state_nx = S_DRAIN;
            S_DRAIN: if (empty && !pop && !push) state_nx = S_DONE;
            S_DONE:  if (bus.en) state_nx = S_DRAIN;
            default: state_nx = S_RUN;
        endcase
    end

    // outputs: the two-slot margin on proceed absorbs one move already in flight from the solver
    always_comb begin
        bus.done    = (state == S_DONE);
        bus.proceed = (state == S_DONE) || (count <= (AW+1)'(DEPTH - 2));
        bus.empty   = empty;
        bus.full    = full;
    end
endmodule

// File: tb/tb_move_player.sv
// tb_move_player: directed self-checking bench for the move player FIFO/replay block
module tb_move_player;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [11:0] q[$];

    move_player_if #(.CNT_W(10)) bus ();

    move_player #(.DEPTH(16), .AUTO_PERIOD(8), .CNT_W(10)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // proceed, stb, display fields, move_count, empty, full, overflow, done
    localparam logic [27:0] RESET_OBS = {1'b1, 1'b0, 12'h000, 10'd0, 1'b1, 3'b000};
    logic [27:0] obs;
    logic [11:0] disp;
    assign obs  = {bus.proceed, bus.stb, bus.disp_start, bus.disp_end, bus.disp_number,
                   bus.move_count, bus.empty, bus.full, bus.overflow, bus.done};
    assign disp = {bus.disp_start, bus.disp_end, bus.disp_number};

    function automatic logic [11:0] pat(input int k);
        logic [3:0] a;
        a = 4'(k);
        return {a, a ^ 4'h5, a + 4'd3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] m);
        bus.en = 1'b1;
        {bus.mv_start, bus.mv_end, bus.mv_number} = m;
        tick();
        bus.en = 1'b0;
    endtask

    task automatic step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs, RESET_OBS);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, RESET_OBS);
        end
    endtask

    task automatic test_basic();
        logic [11:0] exp [3];
        exp[0] = 12'h125;
        exp[1] = 12'h237;
        exp[2] = 12'h569;
        for (int i = 0; i < 3; i++) push(exp[i]);
        checks++;
        if (bus.empty !== 1'b0 || bus.stb !== 1'b0) begin
            errors++;
            $display("FAIL basic_queued: empty=%b stb=%b expected empty=0 stb=0", bus.empty, bus.stb);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.stb !== 1'b1 || disp !== exp[i] || bus.move_count !== 10'(i + 1)) begin
                errors++;
                $display("FAIL basic_pop%0d: stb=%b disp=%h cnt=%0d expected stb=1 disp=%h cnt=%0d",
                         i, bus.stb, disp, bus.move_count, exp[i], i + 1);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty: got %b expected 1", bus.empty);
        end
        tick();
        checks++;
        if (bus.stb !== 1'b0 || disp !== 12'h569) begin
            errors++;
            $display("FAIL basic_hold: stb=%b disp=%h expected stb=0 disp=569", bus.stb, disp);
        end
    endtask

    task automatic test_full();
        do_clear();
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL clear_state: got %h expected %h", obs, RESET_OBS);
        end
        q.delete();
        for (int k = 0; k <= 16; k++) begin
            push(pat(k));
            if (q.size() < 16) q.push_back(pat(k));
            if (k == 13) begin
                checks++;
                if (bus.proceed !== 1'b1 || bus.full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_14: proceed=%b full=%b expected proceed=1 full=0", bus.proceed, bus.full);
                end
            end
            if (k == 14) begin
                checks++;
                if (bus.proceed !== 1'b0 || bus.full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_15: proceed=%b full=%b expected proceed=0 full=0", bus.proceed, bus.full);
                end
            end
            if (k == 15) begin
                checks++;
                if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL full_16: full=%b ovf=%b expected full=1 ovf=0", bus.full, bus.overflow);
                end
            end
            if (k == 16) begin
                checks++;
                if (bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL full_drop: full=%b ovf=%b expected full=1 ovf=1", bus.full, bus.overflow);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp;
        for (int j = 0; j < 40; j++) begin
            bus.en = 1'b1;
            {bus.mv_start, bus.mv_end, bus.mv_number} = pat(j + 20);
            bus.step = 1'b1;
            tick();
            bus.en = 1'b0;
            bus.step = 1'b0;
            exp = q.pop_front();
            q.push_back(pat(j + 20));
            checks++;
            if (bus.stb !== 1'b1 || disp !== exp || bus.full !== 1'b1) begin
                errors++;
                $display("FAIL wrap_pushpop%0d: stb=%b disp=%h full=%b expected stb=1 disp=%h full=1",
                         j, bus.stb, disp, bus.full, exp);
            end
        end
        for (int j = 0; j < 16; j++) begin
            step();
            exp = q.pop_front();
            checks++;
            if (bus.stb !== 1'b1 || disp !== exp) begin
                errors++;
                $display("FAIL wrap_drain%0d: stb=%b disp=%h expected stb=1 disp=%h", j, bus.stb, disp, exp);
            end
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.move_count !== 10'd56 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end: empty=%b cnt=%0d ovf=%b expected empty=1 cnt=56 ovf=1",
                     bus.empty, bus.move_count, bus.overflow);
        end
    endtask

    task automatic test_auto();
        int pulses;
        int first;
        logic [11:0] exp;
        do_clear();
        q.delete();
        for (int k = 40; k < 44; k++) begin
            push(pat(k));
            q.push_back(pat(k));
        end
        bus.auto_play = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (bus.stb === 1'b1) begin
                exp = (q.size() > 0) ? q.pop_front() : 12'hxxx;
                checks++;
                if (t != 8 * (pulses + 1) || disp !== exp) begin
                    errors++;
                    $display("FAIL auto_pulse%0d: cycle=%0d disp=%h expected cycle=%0d disp=%h",
                             pulses, t, disp, 8 * (pulses + 1), exp);
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 4 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL auto_count: pulses=%0d empty=%b expected pulses=4 empty=1", pulses, bus.empty);
        end
        push(pat(50));
        first = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.stb === 1'b1 && first == 0) first = t;
        end
        checks++;
        if (first != 8 || disp !== pat(50)) begin
            errors++;
            $display("FAIL auto_idle_timer: first=%0d disp=%h expected first=8 disp=%h", first, disp, pat(50));
        end
        bus.auto_play = 1'b0;
    endtask

    task automatic test_ignore();
        do_clear();
        step();
        checks++;
        if (bus.stb !== 1'b0 || bus.move_count !== 10'd0) begin
            errors++;
            $display("FAIL ignore_empty: stb=%b cnt=%0d expected stb=0 cnt=0", bus.stb, bus.move_count);
        end
        push(pat(60));
        bus.auto_play = 1'b1;
        step();
        checks++;
        if (bus.stb !== 1'b0 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL ignore_auto: stb=%b empty=%b expected stb=0 empty=0", bus.stb, bus.empty);
        end
        bus.auto_play = 1'b0;
        step();
        checks++;
        if (bus.stb !== 1'b1 || disp !== pat(60)) begin
            errors++;
            $display("FAIL ignore_manual: stb=%b disp=%h expected stb=1 disp=%h", bus.stb, disp, pat(60));
        end
    endtask

    task automatic test_done();
        do_clear();
        push(pat(70));
        push(pat(71));
        bus.solver_done = 1'b1;
        tick();
        bus.solver_done = 1'b0;
        step();
        checks++;
        if (bus.stb !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pop1: stb=%b done=%b expected stb=1 done=0", bus.stb, bus.done);
        end
        step();
        checks++;
        if (bus.stb !== 1'b1 || bus.done !== 1'b0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL done_pop2: stb=%b done=%b empty=%b expected stb=1 done=0 empty=1",
                     bus.stb, bus.done, bus.empty);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.proceed !== 1'b1 || bus.stb !== 1'b0 || disp !== pat(71)) begin
            errors++;
            $display("FAIL done_assert: done=%b proceed=%b stb=%b disp=%h expected done=1 proceed=1 stb=0 disp=%h",
                     bus.done, bus.proceed, bus.stb, disp, pat(71));
        end
        push(pat(72));
        checks++;
        if (bus.done !== 1'b0 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL done_reopen: done=%b empty=%b expected done=0 empty=0", bus.done, bus.empty);
        end
        step();
        tick();
        checks++;
        if (bus.done !== 1'b1 || disp !== pat(72)) begin
            errors++;
            $display("FAIL done_again: done=%b disp=%h expected done=1 disp=%h", bus.done, disp, pat(72));
        end
    endtask

    task automatic test_clear_reset();
        do_clear();
        bus.auto_play = 1'b1;
        for (int k = 80; k < 85; k++) push(pat(k));
        for (int t = 0; t < 3; t++) tick();
        do_clear();
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL clear_midplay: got %h expected %h", obs, RESET_OBS);
        end
        bus.auto_play = 1'b0;
        push(pat(85));
        step();
        checks++;
        if (disp !== pat(85) || bus.move_count !== 10'd1) begin
            errors++;
            $display("FAIL clear_replay: disp=%h cnt=%0d expected disp=%h cnt=1", disp, bus.move_count, pat(85));
        end
        bus.auto_play = 1'b1;
        for (int k = 90; k < 95; k++) push(pat(k));
        for (int t = 0; t < 10; t++) tick();
        checks++;
        if (bus.move_count !== 10'd2 || disp !== pat(90)) begin
            errors++;
            $display("FAIL auto_before_reset: cnt=%0d disp=%h expected cnt=2 disp=%h", bus.move_count, disp, pat(90));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_midplay: got %h expected %h", obs, RESET_OBS);
        end
        bus.auto_play = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(pat(95));
        step();
        checks++;
        if (disp !== pat(95) || bus.move_count !== 10'd1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_replay: disp=%h cnt=%0d empty=%b expected disp=%h cnt=1 empty=1",
                     disp, bus.move_count, bus.empty, pat(95));
        end
    endtask

    initial begin
        bus.clear       = 1'b0;
        bus.en          = 1'b0;
        bus.mv_start    = 4'h0;
        bus.mv_end      = 4'h0;
        bus.mv_number   = 4'h0;
        bus.solver_done = 1'b0;
        bus.step        = 1'b0;
        bus.auto_play   = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_auto();
        test_ignore();
        test_done();
        test_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
